// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmitter.
package i2s_pkg;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 2 * SLOT_BITS;

  typedef enum logic [3:0] {
    S_8BIT  = 4'd0,
    S_12BIT = 4'd1,
    S_16BIT = 4'd3,
    S_24BIT = 4'd4,
    S_32BIT = 4'd5
  } sample_size_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_e;

  // One PCM sample as held between accept and slot load.
  typedef struct packed {
    logic [SLOT_BITS-1:0] data;
    logic [3:0]           size;
  } sample_t;

  // Sample width in bits for a size code; unknown codes mean a full 32-bit sample.
  function automatic logic [5:0] width_of(input logic [3:0] code);
    case (code)
      S_8BIT:  width_of = 6'd8;
      S_12BIT: width_of = 6'd12;
      S_16BIT: width_of = 6'd16;
      S_24BIT: width_of = 6'd24;
      default: width_of = 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV clks while run is high and
// flags the cycle on which bclk is about to fall.
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bclk,
  output logic fall_stb
);

  localparam int             DW     = $clog2(BCLK_DIV);
  localparam logic [DW-1:0]  DIV_TC = DW'(BCLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          tc;

  assign tc       = run && (div_cnt == DIV_TC);
  assign fall_stb = tc && bclk;

  // Divider and bclk; both parked at 0 whenever the transmitter is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter: one-deep sample holding register, 64-bit frame
// counter and MSB-first serialiser. i2s_sdata doubles as the top bit of the
// shift register, so shift_reg carries only the 31 bits still to be sent.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] sample_data,
  input  logic [3:0]  sample_size,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        underrun,
  output logic        busy
);

  state_e        state;
  logic [5:0]    bit_cnt;
  logic [5:0]    nxt_bit;
  logic [30:0]   shift_reg;
  sample_t       hold;
  logic          hold_full;
  logic          fall_stb;
  logic          accept;
  logic          load;
  logic [31:0]   justified;
  logic [31:0]   slot_word;

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
    .clk      (clk),
    .rst      (rst),
    .run      (state != IDLE),
    .bclk     (i2s_bclk),
    .fall_stb (fall_stb)
  );

  assign sample_ready = !hold_full;
  assign accept       = sample_valid && !hold_full;
  assign nxt_bit      = bit_cnt + 6'd1;
  // Slot position 1 is where the MSB goes out (one-BCLK I2S delay).
  assign load         = fall_stb && (nxt_bit[4:0] == 5'd1);
  assign justified    = hold.data << (6'd32 - width_of(hold.size));
  assign slot_word    = hold_full ? justified : '0;

  // Holding register; a load empties it, and since ready is low while full
  // an accept and an emptying load never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (load && hold_full) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= '{data: sample_data, size: sample_size};
      hold_full <= 1'b1;
    end
  end

  // Run/stop FSM plus the serialiser, all stepped on the bclk fall strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      bit_cnt   <= '0;
      i2s_lrclk <= 1'b0;
      i2s_sdata <= 1'b0;
      shift_reg <= '0;
    end else begin
      underrun <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN: if (!enable) state <= STOPPING;
        STOPPING: begin
          if (enable) begin
            state <= RUN;
          end else if (fall_stb && bit_cnt == 6'd63) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (fall_stb) begin
        bit_cnt   <= nxt_bit;
        i2s_lrclk <= nxt_bit[5];
        if (load) begin
          i2s_sdata <= slot_word[31];
          shift_reg <= slot_word[30:0];
          underrun  <= !hold_full;
        end else begin
          i2s_sdata <= shift_reg[30];
          shift_reg <= {shift_reg[29:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: table-driven and random slot words compared
// against a bit-stream model, plus stop, underrun and mid-frame reset sequences.
module tb_i2s_transmitter;

  localparam int DIV = 2;

  typedef struct {
    logic [3:0]  sz;
    logic [31:0] d;
    logic [31:0] w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] sample_data = '0;
  logic [3:0]  sample_size = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, i2s_bclk, i2s_lrclk, i2s_sdata, underrun, busy;

  logic        enable5 = 1'b0;
  logic        ready5, bclk5, lrclk5, sdata5, under5, busy5;

  always #5 clk = ~clk;

  i2s_transmitter #(.BCLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .sample_data(sample_data), .sample_size(sample_size), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sdata(i2s_sdata), .underrun(underrun), .busy(busy)
  );

  i2s_transmitter #(.BCLK_DIV(5)) dut5 (
    .clk(clk), .rst(rst), .enable(enable5),
    .sample_data(32'h0), .sample_size(4'h0), .sample_valid(1'b0),
    .sample_ready(ready5), .i2s_bclk(bclk5), .i2s_lrclk(lrclk5),
    .i2s_sdata(sdata5), .underrun(under5), .busy(busy5)
  );

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Slot word for a sample: width from the size code, sample left-justified.
  function automatic logic [31:0] model_word(input logic [3:0] sz, input logic [31:0] d);
    int w;
    case (sz)
      4'd0:    w = 8;
      4'd1:    w = 12;
      4'd3:    w = 16;
      4'd4:    w = 24;
      default: w = 32;
    endcase
    model_word = d << (32 - w);
  endfunction

  // Stream monitor. The line carries one leading 0 and then every slot word
  // MSB first, back to back; bit n of the line is sent with lrclk = (n/32)%2.
  int          n = 0;
  int          per = 0;
  int          bitpos = 0;
  int          under_cyc = 0;
  logic        prev_bclk = 1'b0;
  logic        frame_ok = 1'b1;
  logic [31:0] acc = '0;

  always @(negedge clk) begin
    if (rst) begin
      n = 0; per = 0; prev_bclk = 1'b0; frame_ok = 1'b1;
    end else begin
      if (underrun) under_cyc++;
      per++;
      if (i2s_bclk && !prev_bclk) begin
        if (n > 0 && per != 2 * DIV) frame_ok = 1'b0;
        per = 0;
        bitpos = n % 64;
        if (i2s_lrclk !== ((n / 32) % 2 == 1)) frame_ok = 1'b0;
        if (n == 0) begin
          check("first_bit", 32'(i2s_sdata), 32'h0);
        end else begin
          acc = {acc[30:0], i2s_sdata};
          if (n % 32 == 0) begin
            if (exp_q.size() > 0) begin
              check("slot_word", acc, exp_q.pop_front());
              check("framing", 32'(frame_ok), 32'h1);
            end
            frame_ok = 1'b1;
          end
        end
        n++;
      end
      prev_bclk = i2s_bclk;
    end
  end

  int   rises5 = 0;
  logic prev5 = 1'b0;
  always @(negedge clk) begin
    if (bclk5 && !prev5) rises5++;
    prev5 = bclk5;
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] sz, input logic [31:0] d, input logic [31:0] w,
                      input bit push);
    int t = 0;
    @(negedge clk);
    sample_valid = 1'b1; sample_size = sz; sample_data = d;
    while (!sample_ready && t < 2000) begin @(negedge clk); t++; end
    if (!sample_ready) timeout("send");
    else if (push) exp_q.push_back(w);
    @(negedge clk);
    // Scramble the bus so a held sample must not depend on it.
    sample_valid = 1'b0; sample_size = 4'($urandom); sample_data = $urandom;
  endtask

  task automatic wait_pos(input int p);
    int t = 0;
    while (bitpos != p && t < 4000) begin step(); t++; end
    if (bitpos != p) timeout($sformatf("bitpos_%0d", p));
  endtask

  task automatic drain;
    int t = 0;
    while (exp_q.size() > 0 && t < 5000) begin step(); t++; end
    if (exp_q.size() > 0) timeout("drain");
  endtask

  vec_t tv[10];

  initial begin
    int c, r0, t;
    logic [3:0]  sz;
    logic [31:0] d;

    tv[0] = '{4'd3, 32'h0000A5A5, 32'hA5A50000};
    tv[1] = '{4'd3, 32'h00001234, 32'h12340000};
    tv[2] = '{4'd0, 32'h00000081, 32'h81000000};
    tv[3] = '{4'd4, 32'h00ABCDEF, 32'hABCDEF00};
    tv[4] = '{4'd5, 32'h80000001, 32'h80000001};
    tv[5] = '{4'd0, 32'hFFFFFF7E, 32'h7E000000};
    tv[6] = '{4'd1, 32'h12345ABC, 32'hABC00000};
    tv[7] = '{4'd3, 32'hDEAD5A5A, 32'h5A5A0000};
    tv[8] = '{4'd4, 32'h7F123456, 32'h12345600};
    tv[9] = '{4'd2, 32'h0000000F, 32'h0000000F};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step();
    check("rst_bclk", 32'(i2s_bclk), 32'h0);
    check("rst_lrclk", 32'(i2s_lrclk), 32'h0);
    check("rst_sdata", 32'(i2s_sdata), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(sample_ready), 32'h1);

    // Pre-fill in IDLE, then stream the table followed by random samples
    send(tv[0].sz, tv[0].d, tv[0].w, 1'b1);
    check("prefill_ready_low", 32'(sample_ready), 32'h0);
    enable = 1'b1;
    for (int i = 1; i < 10; i++) send(tv[i].sz, tv[i].d, tv[i].w, 1'b1);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sz = 4'($urandom); d = $urandom;
      send(sz, d, model_word(sz, d), 1'b1);
    end
    // Nothing more offered: the next two slots go out as zeros with one underrun pulse each.
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    drain();
    check("underrun_cycles", 32'(under_cyc), 32'd2);

    // Stop request at bit 10: frame runs out through bit 63, then idle with bclk low
    wait_pos(10);
    enable = 1'b0;
    r0 = n;
    wait_pos(40);
    check("busy_stopping", 32'(busy), 32'h1);
    t = 0;
    while (busy && t < 2000) begin step(); t++; end
    if (busy) timeout("stop_div2");
    check("stop_rises_div2", 32'(n - r0), 32'd53);
    check("stop_bclk_low", 32'(i2s_bclk), 32'h0);
    check("stop_lrclk_low", 32'(i2s_lrclk), 32'h0);
    r0 = n;
    repeat (20) step();
    check("idle_no_bclk", 32'(n - r0), 32'h0);

    // Same stop sequence with BCLK_DIV=5
    @(negedge clk);
    enable5 = 1'b1;
    t = 0;
    while (!busy5 && t < 20) begin step(); t++; end
    c = 0;
    while (!bclk5 && c < 100) begin step(); c++; end
    check("first_rise_div5", 32'(c), 32'd5);
    r0 = rises5; c = 0;
    while (rises5 == r0 && c < 100) begin step(); c++; end
    check("bclk_period_div5", 32'(c), 32'd10);
    t = 0;
    while (rises5 < 11 && t < 1000) begin step(); t++; end
    enable5 = 1'b0;
    t = 0;
    while (busy5 && t < 2000) begin step(); t++; end
    if (busy5) timeout("stop_div5");
    check("stop_rises_div5", 32'(rises5), 32'd64);
    check("stop_bclk_div5", 32'(bclk5), 32'h0);

    // Reset mid right slot with the holding register full
    send(4'd5, 32'h11111111, 32'h0, 1'b0);
    enable = 1'b1;
    send(4'd5, 32'h22222222, 32'h0, 1'b0);
    send(4'd5, 32'h33333333, 32'h0, 1'b0);
    wait_pos(45);
    check("hold_full_ready", 32'(sample_ready), 32'h0);
    check("mid_right_lrclk", 32'(i2s_lrclk), 32'h1);
    #1 rst = 1'b1; enable = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({i2s_bclk, i2s_lrclk, i2s_sdata, underrun, busy}), 32'h0);
    check("rst_mid_ready", 32'(sample_ready), 32'h1);
    step(); step();
    rst = 1'b0;
    step();
    check("post_rst_ready", 32'(sample_ready), 32'h1);

    // Restart: unknown size code 7 and reserved code 6 are sent as 32-bit samples
    send(4'd7, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    enable = 1'b1;
    send(4'd6, 32'h00000003, 32'h00000003, 1'b1);
    exp_q.push_back(32'h0);
    drain();
    enable = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
